// File: rtl/papuf_crp_driver_if.sv
// Host-side request/response bundle for the PUF challenge/response driver.
// Latency: none, plain wires; timing is owned by papuf_crp_driver.
// Backpressure: none; start is only honoured while busy is low, never queued.
//
// Signals:
//   start          request strobe (host -> driver)
//   ch_in          challenge for the request (host -> driver)
//   busy           request in flight (driver -> host)
//   done           one-cycle strobe, resp_out valid (driver -> host)
//   resp_out       captured or voted response (driver -> host)
//   resp_unstable  per-bit disagreement flags (driver -> host)
interface papuf_crp_driver_if #(
   parameter int CW = 16,
   parameter int RW = 16
) ();
   logic          start;
   logic [CW-1:0] ch_in;
   logic          busy;
   logic          done;
   logic [RW-1:0] resp_out;
   logic [RW-1:0] resp_unstable;

   // master: the host issuing requests
   modport master (
      output start, ch_in,
      input  busy, done, resp_out, resp_unstable
   );

   // slave: the driver serving requests
   modport slave (
      input  start, ch_in,
      output busy, done, resp_out, resp_unstable
   );
endinterface

// File: rtl/papuf_crp_driver.sv
// Pulse-arbiter PUF initiator: drives a challenge, fires the eval pulse, captures the response.
// Latency: start edge to done = SETUP_CYC+PULSE_CYC+CAPTURE_CYC+1 (vote build: NUM_EVAL*(S+P+C)+2).
// Backpressure: start ignored (not queued) while busy; a start in the done cycle is accepted.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   host (slave)    start/ch_in in; busy/done/resp_out/resp_unstable out
//   puf_challenge   registered challenge bus to the PUF array
//   puf_pulse       registered evaluation pulse to the PUF array
//   puf_response    response bus from the PUF array
// Optional feature: define PAPUF_VOTE_EN for NUM_EVAL repeated evaluations with per-bit
// majority vote and instability flags. Without it a single evaluation is captured directly.
module papuf_crp_driver #(
   parameter int CW          = 16,
   parameter int RW          = 16,
   parameter int SETUP_CYC   = 4,
   parameter int PULSE_CYC   = 2,
   parameter int CAPTURE_CYC = 4,
   parameter int NUM_EVAL    = 5
) (
   input  logic            clk,
   input  logic            rst,
   papuf_crp_driver_if.slave host,
   output logic [CW-1:0]   puf_challenge,
   output logic            puf_pulse,
   input  logic [RW-1:0]   puf_response
);

   localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int MAXC   = (MAX_SP > CAPTURE_CYC) ? MAX_SP : CAPTURE_CYC;
   localparam int CNTW   = $clog2(MAXC + 1);

   // Phase counters count down to zero; loaded with N-1 on entry.
   localparam logic [CNTW-1:0] SETUP_LD = CNTW'(SETUP_CYC - 1);
   localparam logic [CNTW-1:0] PULSE_LD = CNTW'(PULSE_CYC - 1);
   localparam logic [CNTW-1:0] CAPT_LD  = CNTW'(CAPTURE_CYC - 1);

   if (SETUP_CYC < 1 || PULSE_CYC < 1 || CAPTURE_CYC < 1 ||
       NUM_EVAL < 1 || (NUM_EVAL % 2) == 0) begin : g_param_check
      $error("papuf_crp_driver: illegal timing or NUM_EVAL parameter");
   end

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      PULSE = 3'd2,
      WAIT  = 3'd3,
      VOTE  = 3'd4
   } state_t;

   state_t          state, state_nxt;
   logic [CNTW-1:0] cyc_cnt, cyc_nxt;
   logic            accept;     // request taken this edge
   logic            sample;     // puf_response captured this edge
   logic            finish;     // done strobes in the following cycle
   logic            last_eval;  // current evaluation is the final one
   logic            done_q;
   logic [RW-1:0]   resp_q;

   assign host.busy     = (state != IDLE);
   assign host.done     = done_q;
   assign host.resp_out = resp_q;

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_nxt = state;
      cyc_nxt   = cyc_cnt;
      accept    = 1'b0;
      sample    = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (host.start) begin
               accept    = 1'b1;
               state_nxt = SETUP;
               cyc_nxt   = SETUP_LD;
            end
         end
         SETUP: begin
            if (cyc_cnt == '0) begin
               state_nxt = PULSE;
               cyc_nxt   = PULSE_LD;
            end else begin
               cyc_nxt = cyc_cnt - 1'b1;
            end
         end
         PULSE: begin
            if (cyc_cnt == '0) begin
               state_nxt = WAIT;
               cyc_nxt   = CAPT_LD;
            end else begin
               cyc_nxt = cyc_cnt - 1'b1;
            end
         end
         WAIT: begin
            if (cyc_cnt == '0) begin
               sample = 1'b1;
               if (!last_eval) begin
                  state_nxt = SETUP;
                  cyc_nxt   = SETUP_LD;
               end else begin
`ifdef PAPUF_VOTE_EN
                  state_nxt = VOTE;
`else
                  state_nxt = IDLE;
                  finish    = 1'b1;
`endif
                  cyc_nxt   = '0;
               end
            end else begin
               cyc_nxt = cyc_cnt - 1'b1;
            end
         end
         VOTE: begin
            state_nxt = IDLE;
            cyc_nxt   = '0;
            finish    = 1'b1;
         end
         default: begin
            state_nxt = IDLE;
            cyc_nxt   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------- control regs
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cyc_cnt       <= '0;
         puf_pulse     <= 1'b0;
         puf_challenge <= '0;
         done_q        <= 1'b0;
      end else begin
         state     <= state_nxt;
         cyc_cnt   <= cyc_nxt;
         // Pulse register follows the next state so it is high exactly in PULSE.
         puf_pulse <= (state_nxt == PULSE);
         done_q    <= finish;
         if (accept) begin
            puf_challenge <= host.ch_in;
         end
      end
   end

   // ---------------------------------------------------------------- capture path
`ifdef PAPUF_VOTE_EN
   localparam int EW = $clog2(NUM_EVAL + 1);

   logic [EW-1:0] eval_cnt;             // evaluations completed for this request
   logic [EW-1:0] ones_cnt [RW];        // per-bit count of sampled ones
   logic [RW-1:0] unst_q;

   assign last_eval          = (eval_cnt == EW'(NUM_EVAL - 1));
   assign host.resp_unstable = unst_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         eval_cnt <= '0;
         resp_q   <= '0;
         unst_q   <= '0;
         for (int i = 0; i < RW; i++) begin
            ones_cnt[i] <= '0;
         end
      end else begin
         if (accept) begin
            eval_cnt <= '0;
            for (int i = 0; i < RW; i++) begin
               ones_cnt[i] <= '0;
            end
         end else if (sample) begin
            eval_cnt <= eval_cnt + 1'b1;
            for (int i = 0; i < RW; i++) begin
               ones_cnt[i] <= ones_cnt[i] + EW'(puf_response[i]);
            end
         end
         if (state == VOTE) begin
            for (int i = 0; i < RW; i++) begin
               resp_q[i] <= (ones_cnt[i] > EW'(NUM_EVAL / 2));
               unst_q[i] <= (ones_cnt[i] != '0) && (ones_cnt[i] != EW'(NUM_EVAL));
            end
         end
      end
   end
`else
   assign last_eval          = 1'b1;
   assign host.resp_unstable = '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_q <= '0;
      end else if (sample) begin
         resp_q <= puf_response;
      end
   end
`endif

endmodule

// File: tb/tb_papuf_crp_driver.sv
// Bench for papuf_crp_driver: directed requests, behavioural PUF model, done-scoreboard.
// Latency: expected done cycle is computed per request from the timing parameters.
// Backpressure: exercises start-while-busy (ignored) and start held through done (accepted).
module tb_papuf_crp_driver;
   localparam int CW = 16;
   localparam int RW = 16;
   localparam int SC = 4;
   localparam int PC = 2;
   localparam int CC = 4;
   localparam int PER = SC + PC + CC;
`ifdef PAPUF_VOTE_EN
   localparam int NEV = 5;
   localparam int LAT = NEV * PER + 2;
`else
   localparam int NEV = 1;
   localparam int LAT = PER + 1;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] puf_challenge;
   logic          puf_pulse;
   logic [RW-1:0] puf_response;

   papuf_crp_driver_if #(.CW(CW), .RW(RW)) host ();

   papuf_crp_driver #(
      .CW(CW), .RW(RW), .SETUP_CYC(SC), .PULSE_CYC(PC), .CAPTURE_CYC(CC), .NUM_EVAL(5)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .host          (host),
      .puf_challenge (puf_challenge),
      .puf_pulse     (puf_pulse),
      .puf_response  (puf_response)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [RW-1:0] resp;
      logic [RW-1:0] unst;
      int            done_cyc;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   logic [RW-1:0] model_q[$];
   int            n_vec = 0;
   int            n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Pulse is expected high only in the PULSE phase of each evaluation.
   function automatic logic exp_pulse(input int m);
      int p, e;
      p = (m - 1) % PER;
      e = (m - 1) / PER;
      return (e < NEV) && (p >= SC) && (p < SC + PC);
   endfunction

   // PUF model: each rising pulse presents the next queued response until the next pulse.
   logic pulse_d = 1'b0;
   always @(negedge clk) begin
      if (puf_pulse && !pulse_d) begin
         if (model_q.size() > 0) puf_response = model_q.pop_front();
         else                    puf_response = 16'hDEAD;
      end
      pulse_d = puf_pulse;
   end

   // Monitor: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && host.done) begin
         if (sb.size() == 0) begin
            check("spurious_done", {31'd0, host.done}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("resp_out", {16'd0, host.resp_out}, {16'd0, mon_e.resp});
            check("resp_unstable", {16'd0, host.resp_unstable}, {16'd0, mon_e.unst});
            check("done_cycle", cyc, mon_e.done_cyc);
            check("busy_in_done", {31'd0, host.busy}, 32'd0);
         end
      end
   end

   task automatic push_model(input logic [RW-1:0] r, input int cnt);
      for (int i = 0; i < cnt; i++) model_q.push_back(r);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},  {31'd0, host.busy}, 32'd0);
      check({tag, "_done"},  {31'd0, host.done}, 32'd0);
      check({tag, "_pulse"}, {31'd0, puf_pulse}, 32'd0);
      check({tag, "_chal"},  {16'd0, puf_challenge}, 32'd0);
      check({tag, "_resp"},  {16'd0, host.resp_out}, 32'd0);
      check({tag, "_unst"},  {16'd0, host.resp_unstable}, 32'd0);
   endtask

   // Single request: start for one cycle, then let it run to completion.
   task automatic simple_req(input logic [CW-1:0] ch, input logic [RW-1:0] r,
                             input logic [RW-1:0] vr, input logic [RW-1:0] vu);
      int s;
      @(negedge clk);
      s = cyc;
      host.start = 1'b1;
      host.ch_in = ch;
      sb.push_back('{vr, vu, s + LAT});
      @(negedge clk);
      host.start = 1'b0;
      check("simple_chal", {16'd0, puf_challenge}, {16'd0, ch});
      repeat (LAT + 1) @(negedge clk);
   endtask

   initial begin
      int s, n, r, m;
      logic [CW-1:0] ch_exp;

      // ---- reset state
      rst = 1'b1;
      host.start = 1'b0;
      host.ch_in = '0;
      puf_response = '0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // ---- first request A5C3 -> 3C5A, ignored start while busy,
      //      start held through done -> back-to-back 0001 -> 0F0F
      push_model(16'h3C5A, NEV);
      push_model(16'h0F0F, NEV);
      s = cyc;
      host.start = 1'b1;
      host.ch_in = 16'hA5C3;
      sb.push_back('{16'h3C5A, 16'h0000, s + LAT});
      sb.push_back('{16'h0F0F, 16'h0000, s + 2 * LAT});
      for (n = 1; n <= 2 * LAT; n++) begin
         @(negedge clk);
         r = (n - 1) / LAT;
         m = (n - 1) % LAT + 1;
         ch_exp = (r == 0) ? 16'hA5C3 : 16'h0001;
         check("chal_hold", {16'd0, puf_challenge}, {16'd0, ch_exp});
         if (m < LAT) begin
            check("busy", {31'd0, host.busy}, 32'd1);
            check("pulse", {31'd0, puf_pulse}, {31'd0, exp_pulse(m)});
         end else begin
            check("pulse_done", {31'd0, puf_pulse}, 32'd0);
         end
         if (n == 1)            host.start = 1'b0;
         if (n == 3) begin      host.start = 1'b1; host.ch_in = 16'hFFFF; end
         if (n == 5)            host.start = 1'b0;
         if (n == LAT - 2) begin host.start = 1'b1; host.ch_in = 16'h0001; end
         if (n == LAT + 1)      host.start = 1'b0;
      end

      // ---- reset mid-evaluation aborts with no done
      @(negedge clk);
      push_model(16'h5555, NEV);
      host.start = 1'b1;
      host.ch_in = 16'h00FF;
      for (n = 1; n <= SC + 1; n++) begin
         @(negedge clk);
         if (n == 1) host.start = 1'b0;
      end
      check("abort_pulse_before", {31'd0, puf_pulse}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_idle_outputs("abort");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_q.delete();
      repeat (LAT + 5) @(negedge clk);
      check("abort_idle", {31'd0, host.busy}, 32'd0);

      // ---- plain request after reset, all-ones response
      push_model(16'hFFFF, NEV);
      simple_req(16'h5A5A, 16'hFFFF, 16'hFFFF, 16'h0000);

`ifdef PAPUF_VOTE_EN
      // ---- majority vote with an unstable bit 0
      model_q.push_back(16'h8001);
      model_q.push_back(16'h8000);
      model_q.push_back(16'h8001);
      model_q.push_back(16'h8001);
      model_q.push_back(16'h8000);
      simple_req(16'h1111, 16'h8001, 16'h8001, 16'h0001);

      // ---- fully stable response
      push_model(16'h1234, NEV);
      simple_req(16'h2222, 16'h1234, 16'h1234, 16'h0000);
`endif

      // ---- drain scoreboard with a bounded wait
      for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
      check("scoreboard_drained", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
